mem_arbiter: RTL and testbench

Single-port memory arbiter sitting between one CPU's instruction/data cache pair and the shared RAM. It services the cache-side request protocol (iREN / dREN / dWEN with iwait / dwait), grants one requester at a time to the RAM, and returns completion and load data. Arbitration is registered, with data-first priority, alternation under contention, a per-access timeout and a sticky error flag.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for an I/D cache pair.
// Registered grant, data-first alternation, per-access timeout, sticky error.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [31:0] CNT_LAST  = 32'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic        memerr_q, memerr_d;

  logic d_req;
  logic cur_req;
  logic cur_is_d;

  assign d_req = dREN | dWEN;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      memerr_q <= memerr_d;
    end
  end

  always_comb begin
    cur_is_d = (state_q == GNT_D);
    cur_req  = cur_is_d ? d_req : iREN;
  end

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    memerr_d = memerr_q;
    case (state_q)
      IDLE: begin
        // With both pending, serve the side not served last.
        if (d_req && (!iREN || !last_d_q)) begin
          state_d = GNT_D;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          cnt_d   = '0;
        end else if (iREN) begin
          state_d = GNT_I;
          addr_d  = iaddr;
          wr_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      GNT_I, GNT_D: begin
        if (!cur_req) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          state_d  = IDLE;
          last_d_d = cur_is_d;
        end else if (ramstate == RAM_ERROR) begin
          state_d  = IDLE;
          last_d_d = cur_is_d;
          memerr_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          memerr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    case (state_q)
      GNT_I: begin
        ramREN = 1'b1;
        iwait  = !(iREN && ramstate == RAM_ACCESS);
      end
      GNT_D: begin
        ramREN = !wr_q;
        ramWEN = wr_q;
        dwait  = !(d_req && ramstate == RAM_ACCESS);
      end
      default: ;
    endcase
  end

  assign iload    = ramload;
  assign dload    = ramload;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign memerr   = memerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a completion scoreboard.
// Inputs change 1ns after the rising edge; outputs sampled on the falling edge.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1;
  localparam logic [1:0] ACC = 2'd2, ERR = 2'd3;

  typedef struct {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .memerr(memerr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge CLK);
    chk("one_wait", 32'(!(!iwait && !dwait)), 32'd1);
    chk("one_strobe", 32'(!(ramREN && ramWEN)), 32'd1);
    if (!iwait || !dwait) begin
      chk("sb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_side", 32'(!dwait), 32'(e.is_d));
        chk("sb_data", e.is_d ? dload : iload, e.data);
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    cyc();
    cyc();
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = FREE;
    cyc();
    do_reset();

    sample();
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_ren", 32'(ramREN), 32'd0);
    chk("rst_wen", 32'(ramWEN), 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_store", ramstore, 32'd0);
    chk("rst_memerr", 32'(memerr), 32'd0);
    cyc();

    // instruction read, immediate ACCESS
    iREN = 1; iaddr = 32'h40;
    sample(); chk("i_idle_ren", 32'(ramREN), 32'd0); cyc();
    ramstate = ACC; ramload = 32'hDEADBEEF;
    push(1'b0, 32'hDEADBEEF);
    sample();
    chk("i_ren", 32'(ramREN), 32'd1);
    chk("i_addr", ramaddr, 32'h40);
    chk("i_iwait", 32'(iwait), 32'd0);
    chk("i_dwait", 32'(dwait), 32'd1);
    cyc();
    iREN = 0; ramstate = FREE;
    sample(); chk("i_done_ren", 32'(ramREN), 32'd0); cyc();
    chk("i_drained", exp_q.size(), 0);

    // data write, three BUSY cycles then ACCESS
    dWEN = 1; daddr = 32'h100; dstore = 32'h12345678; ramstate = BUSY;
    sample(); cyc();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin daddr = 32'h999; dstore = 32'h0; end
      ramstate = (k == 3) ? ACC : BUSY;
      ramload = 32'h5A5A0000 + 32'(k);
      if (k == 3) push(1'b1, 32'h5A5A0003);
      sample();
      chk("w_wen", 32'(ramWEN), 32'd1);
      chk("w_ren", 32'(ramREN), 32'd0);
      chk("w_addr", ramaddr, 32'h100);
      chk("w_store", ramstore, 32'h12345678);
      chk("w_dwait", 32'(dwait), (k == 3) ? 32'd0 : 32'd1);
      cyc();
    end
    dWEN = 0; ramstate = FREE;
    sample(); chk("w_done_wen", 32'(ramWEN), 32'd0); cyc();
    chk("w_drained", exp_q.size(), 0);

    // contention alternation from reset: D, I, D, I
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h200; daddr = 32'h300;
    ramstate = ACC;
    sample(); cyc();
    for (int g = 0; g < 4; g++) begin
      ramload = 32'hA0 + 32'(g);
      push((g % 2) == 0, 32'hA0 + 32'(g));
      sample();
      chk("alt_ren", 32'(ramREN), 32'd1);
      chk("alt_addr", ramaddr, ((g % 2) == 0) ? 32'h300 : 32'h200);
      cyc();
      if (g == 3) begin iREN = 0; dREN = 0; end
      sample();
      chk("alt_idle_ren", 32'(ramREN), 32'd0);
      cyc();
    end
    chk("alt_drained", exp_q.size(), 0);

    // timeout after 8 grant cycles without ACCESS
    dREN = 1; daddr = 32'h500; ramstate = BUSY;
    sample(); cyc();
    for (int k = 0; k < 8; k++) begin
      if (k == 7) dREN = 1;
      sample();
      chk("to_ren", 32'(ramREN), 32'd1);
      chk("to_dwait", 32'(dwait), 32'd1);
      chk("to_memerr_lo", 32'(memerr), 32'd0);
      cyc();
    end
    dREN = 0;
    sample();
    chk("to_idle_ren", 32'(ramREN), 32'd0);
    chk("to_memerr", 32'(memerr), 32'd1);
    cyc();
    iREN = 1; iaddr = 32'h44;
    sample(); cyc();
    ramstate = ACC; ramload = 32'h1111;
    push(1'b0, 32'h1111);
    sample(); cyc();
    iREN = 0; ramstate = FREE;
    sample(); chk("to_sticky", 32'(memerr), 32'd1); cyc();
    chk("to_drained", exp_q.size(), 0);

    // RAM ERROR during an I grant, pending D follows
    do_reset();
    iREN = 1; iaddr = 32'h60;
    sample(); cyc();
    dREN = 1; daddr = 32'h600; ramstate = ERR;
    sample();
    chk("err_ren", 32'(ramREN), 32'd1);
    chk("err_iwait", 32'(iwait), 32'd1);
    chk("err_memerr_lo", 32'(memerr), 32'd0);
    cyc();
    iREN = 0; ramstate = FREE;
    sample();
    chk("err_memerr", 32'(memerr), 32'd1);
    chk("err_idle_ren", 32'(ramREN), 32'd0);
    cyc();
    ramstate = ACC; ramload = 32'h77;
    push(1'b1, 32'h77);
    sample();
    chk("err_d_ren", 32'(ramREN), 32'd1);
    chk("err_d_addr", ramaddr, 32'h600);
    cyc();
    dREN = 0; ramstate = FREE;
    sample(); cyc();
    chk("err_drained", exp_q.size(), 0);

    // requester drops mid-grant: no pulse even with ACCESS
    iREN = 1; iaddr = 32'h700; ramstate = BUSY;
    sample(); cyc();
    sample(); chk("drop_ren", 32'(ramREN), 32'd1); cyc();
    iREN = 0; ramstate = ACC;
    sample(); chk("drop_iwait", 32'(iwait), 32'd1); cyc();
    ramstate = FREE;
    sample(); chk("drop_idle_ren", 32'(ramREN), 32'd0); cyc();

    // reset asserted mid-grant
    dWEN = 1; daddr = 32'h800; dstore = 32'hAA; ramstate = BUSY;
    sample(); cyc();
    sample(); chk("mr_wen", 32'(ramWEN), 32'd1); cyc();
    nRST = 0;
    sample(); cyc();
    nRST = 1; dWEN = 0; ramstate = FREE;
    sample();
    chk("mr_wen_lo", 32'(ramWEN), 32'd0);
    chk("mr_ren_lo", 32'(ramREN), 32'd0);
    chk("mr_dwait", 32'(dwait), 32'd1);
    chk("mr_iwait", 32'(iwait), 32'd1);
    chk("mr_addr", ramaddr, 32'd0);
    chk("mr_store", ramstore, 32'd0);
    chk("mr_memerr", 32'(memerr), 32'd0);
    cyc();
    chk("final_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
